// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial BCD adder sequencer. One decimal-correcting digit adder is
// reused across DIGITS digits, least-significant digit first.
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_next;

  // Digit-indexed views of the captured operands and the running result.
  logic [DIGITS-1:0][3:0] op_a, op_b, acc, acc_next;
  logic [IDX_W-1:0]       idx;
  logic                   carry, err_acc;

  logic [3:0] a_d, b_d, digit;
  logic [4:0] raw;
  logic       carry_next, digit_bad, capture, last;

  assign last = (idx == LAST);
  assign busy = (state == ADD);
  assign done = (state == DONE);

  // NOTE: every always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    a_d        = op_a[idx];
    b_d        = op_b[idx];
    raw        = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, carry};
    digit      = raw[3:0];
    carry_next = 1'b0;
    if (raw > 5'd9) begin
      digit      = raw[3:0] + 4'd6;
      carry_next = 1'b1;
    end
    digit_bad     = (a_d > 4'd9) || (b_d > 4'd9);
    acc_next      = acc;
    acc_next[idx] = digit;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = ADD;
        end else begin
          state_next = IDLE;
        end
      end
      ADD:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: all datapath registers are reset too, because an aborted
  // operation must leave sum/cout/err at zero rather than stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      acc     <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      err_acc <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      err     <= 1'b0;
    end else if (capture) begin
      op_a    <= a;
      op_b    <= b;
      carry   <= cin;
      acc     <= '0;
      idx     <= '0;
      err_acc <= 1'b0;
    end else if (state == ADD) begin
      acc     <= acc_next;
      carry   <= carry_next;
      err_acc <= err_acc | digit_bad;
      if (last) begin
        // Outputs only change here, so a partial result is never visible.
        idx  <= '0;
        sum  <= acc_next;
        cout <= carry_next;
        err  <= err_acc | digit_bad;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Self-checking bench for bcd_serial_adder_ctrl: decimal reference model with
// a per-cycle compare process, plus directed vectors with literal results.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal arithmetic for valid operands; the per-digit
  // "+6 when above nine" rule only when some digit is not decimal.
  function automatic void bcd_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic c, output logic [W-1:0] s,
                                  output logic co, output logic e);
    longint vx = 0, vy = 0, t, p = 1;
    int     dx, dy, r, cc;
    e = 1'b0;
    s = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      dx = int'(x[4*i +: 4]);
      dy = int'(y[4*i +: 4]);
      if (dx > 9 || dy > 9) e = 1'b1;
      vx = vx * 10 + dx;
      vy = vy * 10 + dy;
      p  = p * 10;
    end
    if (!e) begin
      t  = vx + vy + longint'(c);
      co = (t >= p);
      t  = t % p;
      for (int i = 0; i < DIGITS; i++) begin
        s[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end else begin
      cc = int'(c);
      for (int i = 0; i < DIGITS; i++) begin
        r  = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
        cc = (r > 9) ? 1 : 0;
        if (r > 9) r = (r + 6) % 16;
        s[4*i +: 4] = 4'(r);
      end
      co = cc[0];
    end
  endfunction

  // Cycle-level expectation: a countdown of remaining busy cycles.
  int           m_cnt;
  logic         m_done, m_cout, m_err, p_cout, p_err;
  logic [W-1:0] m_sum, p_sum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_err  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_sum  = p_sum;
          m_cout = p_cout;
          m_err  = p_err;
        end
      end else if (start) begin
        bcd_ref(a, b, cin, p_sum, p_cout, p_err);
        m_cnt = DIGITS;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    check("busy", busy, m_cnt > 0);
    check("done", done, m_done);
    check("sum", sum, m_sum);
    check("cout", cout, m_cout);
    check("err", err, m_err);
    check("busy_done_excl", busy & done, 1'b0);
  end

  // One operation with literal expectations. Operands are scrambled right
  // after capture to show they have no further effect.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic [W-1:0] es, input logic ec, input logic ee,
                        input string name);
    int n;
    @(negedge clk);
    a = ta; b = tb_; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ta ^ 16'h5a5a; b = tb_ ^ 16'h3c3c; cin = ~tc;
    n = 0;
    while (!done && n < DIGITS + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, n, DIGITS);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
    check({name, "_err"}, err, ee);
  endtask

  logic [W-1:0] ra, rb, rs;
  logic         rc, rco, re;
  int           n;

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_err", err, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    run_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, "basic");
    run_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple");
    run_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, "max");
    run_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, "cin_only");
    run_op(16'h00a0, 16'h0000, 1'b0, 16'h0100, 1'b0, 1'b1, "bad_digit");
    run_op(16'h0042, 16'h0007, 1'b0, 16'h0049, 1'b0, 1'b0, "err_clear");

    // Start during ADD with different operands is ignored.
    @(negedge clk); a = 16'h2500; b = 16'h2500; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < DIGITS + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore_sum", sum, 16'h5000);
    @(posedge clk); #1;
    check("ignore_no_restart", busy, 1'b0);

    // start held through DONE: back-to-back, done spacing DIGITS+1.
    @(negedge clk); a = 16'h0123; b = 16'h0456; cin = 1'b0; start = 1'b1;
    n = 0;
    while (!done && n < DIGITS + 4) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first_sum", sum, 16'h0579);
    a = 16'h0808; b = 16'h0303;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < DIGITS + 6) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_spacing", n, DIGITS + 1);
    check("b2b_second_sum", sum, 16'h1111);

    // Reset two cycles into ADD aborts with everything cleared at once.
    @(negedge clk); a = 16'h0001; b = 16'h0001; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum, 16'h0000);
    check("abort_cout", cout, 1'b0);
    check("abort_err", err, 1'b0);
    repeat (DIGITS + 1) @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0500, 16'h0500, 1'b0, 16'h1000, 1'b0, 1'b0, "after_reset");

    // Random valid BCD sweep; expectations from the decimal model.
    for (int k = 0; k < 1000; k++) begin
      for (int d = 0; d < DIGITS; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      bcd_ref(ra, rb, rc, rs, rco, re);
      run_op(ra, rb, rc, rs, rco, re, "rand");
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
